// File: rtl/biplex_pkg.sv
// Shared types and helpers for the Biplex FFT output reorder buffer.
// The bit-reversed drain order is selected by BIPLEX_REORDER_BITREV_EN in the read block.
package biplex_pkg;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_READ = 1'b1
  } rd_state_t;

  // Enabled edges from a registered read address to the registered output sample.
  localparam int RD_LAT       = 2;
  localparam int BITREV_MAX_W = 16;
  localparam int BITREV_IDX_W = $clog2(BITREV_MAX_W);

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [BITREV_MAX_W-1:0] bitrev(input logic [BITREV_MAX_W-1:0] v,
                                                     input int w);
    logic [BITREV_MAX_W-1:0] r;
    logic [BITREV_IDX_W-1:0] idx;
    r = '0;
    for (int i = 0; i < BITREV_MAX_W; i++) begin
      if (i < w) begin
        idx = BITREV_IDX_W'(w - 1 - i);
        r[BITREV_IDX_W'(i)] = v[idx];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/biplex_reorder_rd_if.sv
// Signal bundle between the reorder read block (slave) and its environment (master).
// Strobe semantics: wr_bank is qualified by wr_done, dout/sync_out by dout_vld, all only on ena cycles.
interface biplex_reorder_rd_if
  import biplex_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 36
);
  logic              ena;
  logic              wr_done;
  logic              wr_bank;
  logic [ADDR_W:0]   rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              sync_out;
  logic              overrun;
  rd_state_t         dbg_state;

  modport slave (
    input  ena, wr_done, wr_bank, rd_data,
    output rd_addr, dout, dout_vld, sync_out, overrun, dbg_state
  );

  modport master (
    output ena, wr_done, wr_bank, rd_data,
    input  rd_addr, dout, dout_vld, sync_out, overrun, dbg_state
  );
endinterface

// File: rtl/reorder_rd_pipe.sv
// Tag delay line (vld/first) matched to the RAM read latency, plus the output data register.
module reorder_rd_pipe
  import biplex_pkg::*;
#(
  parameter int DATA_W = 36
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ena,
  input  logic              i_vld,
  input  logic              i_first,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_vld,
  output logic              o_sync
);

  logic [RD_LAT-1:0] r_vld;
  logic [RD_LAT-1:0] r_first;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_first <= '0;
      r_data  <= '0;
    end else if (i_ena) begin
      r_vld   <= {r_vld[RD_LAT-2:0], i_vld};
      r_first <= {r_first[RD_LAT-2:0], i_first};
      r_data  <= i_data;
    end
  end

  assign o_data = r_data;
  assign o_vld  = r_vld[RD_LAT-1];
  assign o_sync = r_vld[RD_LAT-1] & r_first[RD_LAT-1];

endmodule

// File: rtl/biplex_reorder_rd.sv
// Read side of the Biplex reorder buffer: drains completed ping-pong banks as framed samples.
// Define BIPLEX_REORDER_BITREV_EN for bit-reversed offsets; otherwise offsets run in natural order.
module biplex_reorder_rd
  import biplex_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 36
) (
  input  logic                 clk,
  input  logic                 rst,
  biplex_reorder_rd_if.slave   bus
);

  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [1:0]        r_pending;
  logic [1:0]        w_pending_nxt;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;
  logic              r_rd_bank;
  logic              w_rd_bank_nxt;
  logic              w_nb;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [ADDR_W-1:0] w_off;
  logic              w_issue;
  logic              w_issue_first;
  logic              w_overrun_evt;
  logic [ADDR_W:0]   r_rd_addr;
  logic              r_iss_vld;
  logic              r_iss_first;
  logic              r_overrun;

`ifdef BIPLEX_REORDER_BITREV_EN
  assign w_off = ADDR_W'(bitrev(BITREV_MAX_W'(r_cnt), ADDR_W));
`else
  assign w_off = r_cnt;
`endif

  assign w_nb = ~r_rd_bank;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_rd_bank_nxt = r_rd_bank;
    w_clr         = '0;
    w_set         = '0;
    w_issue       = 1'b0;
    w_issue_first = 1'b0;
    if (bus.wr_done) w_set[bus.wr_bank] = 1'b1;

    case (r_state)
      RD_IDLE: begin
        if (r_pending[r_rd_bank]) begin
          w_state_nxt        = RD_READ;
          w_clr[r_rd_bank]   = 1'b1;
          w_issue            = 1'b1;
          w_issue_first      = 1'b1;
          w_cnt_nxt          = ADDR_W'(1);
        end
      end
      RD_READ: begin
        w_issue       = 1'b1;
        w_issue_first = (r_cnt == '0);
        w_cnt_nxt     = r_cnt + ADDR_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_rd_bank_nxt = w_nb;
          // A bank completing in this very cycle is consumed without a gap.
          if (r_pending[w_nb] || w_set[w_nb]) w_clr[w_nb] = 1'b1;
          else                                 w_state_nxt = RD_IDLE;
        end
      end
      default: w_state_nxt = RD_IDLE;
    endcase

    // A new completion on a bank that was already pending survives its own clear.
    w_pending_nxt = ((r_pending | w_set) & ~w_clr) | (r_pending & w_set);
    w_overrun_evt = bus.wr_done &&
                    (r_pending[bus.wr_bank] || (r_state == RD_READ && bus.wr_bank == r_rd_bank));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RD_IDLE;
      r_pending   <= '0;
      r_rd_bank   <= 1'b0;
      r_cnt       <= '0;
      r_rd_addr   <= '0;
      r_iss_vld   <= 1'b0;
      r_iss_first <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (bus.ena) begin
      r_state     <= w_state_nxt;
      r_pending   <= w_pending_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_cnt       <= w_cnt_nxt;
      r_iss_vld   <= w_issue;
      r_iss_first <= w_issue_first;
      r_overrun   <= r_overrun | w_overrun_evt;
      if (w_issue) r_rd_addr <= {r_rd_bank, w_off};
    end
  end

  reorder_rd_pipe #(.DATA_W(DATA_W)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_ena   (bus.ena),
    .i_vld   (r_iss_vld),
    .i_first (r_iss_first),
    .i_data  (bus.rd_data),
    .o_data  (bus.dout),
    .o_vld   (bus.dout_vld),
    .o_sync  (bus.sync_out)
  );

  assign bus.rd_addr   = r_rd_addr;
  assign bus.overrun   = r_overrun;
  assign bus.dbg_state = r_state;

endmodule
